// File: rtl/bsg_manycore_bank_arb_pkg.sv
// Width helpers shared by the bank arbiter and its per-bank picker.
package bsg_manycore_bank_arb_pkg;

  // Bank index register width; never zero so a single-bank build still has a field.
  function automatic int unsigned lg_banks(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Address bits consumed by bank select (zero for a single bank).
  function automatic int unsigned bank_sel_width(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  // One byte-enable bit per byte of the data word.
  function automatic int unsigned mask_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Starvation counter width, wide enough to hold the saturation value.
  function automatic int unsigned wait_width(input int unsigned starve_limit);
    return $clog2(starve_limit + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_bank_arb_pick.sv
// Per-bank grant picker: urgent candidates first, then highest index wins.
module bsg_manycore_bank_arb_pick #(
  parameter int unsigned num_ports_p = 3
) (
  input  logic [num_ports_p-1:0] i_cand,
  input  logic [num_ports_p-1:0] i_urgent,
  output logic [num_ports_p-1:0] o_grant_c
);

  logic [num_ports_p-1:0] w_urg;
  logic [num_ports_p-1:0] w_pool;

  // Restrict to urgent candidates when any exist, then one-hot the top bit.
  always_comb begin
    w_urg     = i_cand & i_urgent;
    w_pool    = (|w_urg) ? w_urg : i_cand;
    o_grant_c = '0;
    for (int p = 0; p < int'(num_ports_p); p++) begin
      if (w_pool[p]) begin
        o_grant_c    = '0;
        o_grant_c[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_bank_arbiter.sv
// Banked local-memory arbiter: steers requests to banks, ages starving
// requesters, and returns read data to the originating port one cycle later.
module bsg_manycore_bank_arbiter
  import bsg_manycore_bank_arb_pkg::*;
#(
  parameter int unsigned num_ports_p    = 3,
  parameter int unsigned num_banks_p    = 2,
  parameter int unsigned bank_size_p    = 1024,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned starve_limit_p = 4,
  localparam int unsigned lg_banks_lp        = lg_banks(num_banks_p),
  localparam int unsigned sel_width_lp       = bank_sel_width(num_banks_p),
  localparam int unsigned bank_addr_width_lp = $clog2(bank_size_p),
  localparam int unsigned addr_width_lp      = bank_addr_width_lp + sel_width_lp,
  localparam int unsigned mask_width_lp      = mask_width(data_width_p),
  localparam int unsigned wait_width_lp      = wait_width(starve_limit_p)
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  input  logic [num_ports_p-1:0]                           v_i,
  input  logic [num_ports_p-1:0]                           w_i,
  input  logic [num_ports_p-1:0][addr_width_lp-1:0]        addr_i,
  input  logic [num_ports_p-1:0][data_width_p-1:0]         data_i,
  input  logic [num_ports_p-1:0][mask_width_lp-1:0]        mask_i,
  output logic [num_ports_p-1:0]                           yumi_o,
  output logic [num_ports_p-1:0]                           v_o,
  output logic [num_ports_p-1:0][data_width_p-1:0]         data_o,
  output logic [num_banks_p-1:0]                           bank_v_o,
  output logic [num_banks_p-1:0]                           bank_w_o,
  output logic [num_banks_p-1:0][bank_addr_width_lp-1:0]   bank_addr_o,
  output logic [num_banks_p-1:0][data_width_p-1:0]         bank_data_o,
  output logic [num_banks_p-1:0][mask_width_lp-1:0]        bank_mask_o,
  input  logic [num_banks_p-1:0][data_width_p-1:0]         bank_data_i
);

  localparam logic [wait_width_lp-1:0] limit_lp = wait_width_lp'(starve_limit_p);

  logic [num_ports_p-1:0][wait_width_lp-1:0]      r_wait;
  logic [num_ports_p-1:0]                         r_rd_v;
  logic [num_ports_p-1:0][lg_banks_lp-1:0]        r_rd_bank;

  logic [num_ports_p-1:0][lg_banks_lp-1:0]        w_bank_sel;
  logic [num_ports_p-1:0][bank_addr_width_lp-1:0] w_bank_local;
  logic [num_ports_p-1:0]                         w_urgent;
  logic [num_banks_p-1:0][num_ports_p-1:0]        w_cand;
  logic [num_banks_p-1:0][num_ports_p-1:0]        w_grant;
  logic [num_ports_p-1:0]                         w_yumi;

  // Split each address into bank select (low bits) and bank-local word address.
  for (genvar p = 0; p < num_ports_p; p++) begin : g_addr
    if (num_banks_p > 1) begin : g_multi
      assign w_bank_sel[p]   = lg_banks_lp'(addr_i[p][sel_width_lp-1:0]);
      assign w_bank_local[p] = addr_i[p][addr_width_lp-1:sel_width_lp];
    end else begin : g_single
      assign w_bank_sel[p]   = '0;
      assign w_bank_local[p] = addr_i[p];
    end
    assign w_urgent[p] = (r_wait[p] == limit_lp);
  end

  // Candidate matrix: valid ports whose bank select matches each bank.
  always_comb begin
    w_cand = '0;
    for (int b = 0; b < int'(num_banks_p); b++) begin
      for (int p = 0; p < int'(num_ports_p); p++) begin
        w_cand[b][p] = v_i[p] && (w_bank_sel[p] == lg_banks_lp'(b));
      end
    end
  end

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    bsg_manycore_bank_arb_pick #(
      .num_ports_p(num_ports_p)
    ) u_pick (
      .i_cand    (w_cand[b]),
      .i_urgent  (w_urgent),
      .o_grant_c (w_grant[b])
    );
  end

  // Merge per-bank grants into per-port accepts; everything quiet under reset.
  always_comb begin
    w_yumi = '0;
    for (int b = 0; b < int'(num_banks_p); b++) begin
      w_yumi = w_yumi | w_grant[b];
    end
    yumi_o = w_yumi & {num_ports_p{reset_n_i}};
  end

  // Drive each bank from its winner; idle banks drive zeros.
  always_comb begin
    bank_v_o    = '0;
    bank_w_o    = '0;
    bank_addr_o = '0;
    bank_data_o = '0;
    bank_mask_o = '0;
    for (int b = 0; b < int'(num_banks_p); b++) begin
      for (int p = 0; p < int'(num_ports_p); p++) begin
        if (w_grant[b][p] && reset_n_i) begin
          bank_v_o[b]    = 1'b1;
          bank_w_o[b]    = w_i[p];
          bank_addr_o[b] = w_bank_local[p];
          bank_data_o[b] = data_i[p];
          bank_mask_o[b] = mask_i[p];
        end
      end
    end
  end

  // Starvation aging: count denied cycles, saturate, clear on grant or idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wait <= '0;
    end else begin
      for (int p = 0; p < int'(num_ports_p); p++) begin
        if (!v_i[p] || w_yumi[p]) begin
          r_wait[p] <= '0;
        end else if (r_wait[p] != limit_lp) begin
          r_wait[p] <= r_wait[p] + wait_width_lp'(1);
        end
      end
    end
  end

  // Read return pipeline: remember which bank a granted read went to.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_v    <= '0;
      r_rd_bank <= '0;
    end else begin
      for (int p = 0; p < int'(num_ports_p); p++) begin
        r_rd_v[p] <= w_yumi[p] && !w_i[p];
        if (w_yumi[p] && !w_i[p]) begin
          r_rd_bank[p] <= w_bank_sel[p];
        end
      end
    end
  end

  // Steer bank read data back to the requesting port.
  always_comb begin
    v_o = r_rd_v & {num_ports_p{reset_n_i}};
    for (int p = 0; p < int'(num_ports_p); p++) begin
      data_o[p] = bank_data_i[r_rd_bank[p]];
    end
  end

endmodule

// File: tb/tb_bsg_manycore_bank_arbiter.sv
// Directed bench for the bank arbiter (3 ports, 2 banks, starve limit 4).
module tb_bsg_manycore_bank_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned NB = 2;
  localparam int unsigned AW = 11;
  localparam int unsigned BAW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam logic [DW-1:0] B0_DATA = 32'hA0A0_0000;
  localparam logic [DW-1:0] B1_DATA = 32'hB1B1_1111;

  logic                      clk;
  logic                      reset_n_i;
  logic [NP-1:0]             v_i, w_i, yumi_o, v_o;
  logic [NP-1:0][AW-1:0]     addr_i;
  logic [NP-1:0][DW-1:0]     data_i, data_o;
  logic [NP-1:0][MW-1:0]     mask_i;
  logic [NB-1:0]             bank_v_o, bank_w_o;
  logic [NB-1:0][BAW-1:0]    bank_addr_o;
  logic [NB-1:0][DW-1:0]     bank_data_o, bank_data_i;
  logic [NB-1:0][MW-1:0]     bank_mask_o;

  int n_checks;
  int n_pass;

  bsg_manycore_bank_arbiter #(
    .num_ports_p(NP), .num_banks_p(NB), .bank_size_p(1024),
    .data_width_p(DW), .starve_limit_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o),
    .bank_v_o(bank_v_o), .bank_w_o(bank_w_o), .bank_addr_o(bank_addr_o),
    .bank_data_o(bank_data_o), .bank_mask_o(bank_mask_o), .bank_data_i(bank_data_i)
  );

  always #5 clk = ~clk;

  task automatic idle();
    v_i = '0; w_i = '0; addr_i = '0; data_i = '0; mask_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    idle();
    v_i = 3'b111;
    #2;
    n_checks++;
    if (yumi_o !== 3'b000) $display("FAIL reset_yumi got=%b exp=000", yumi_o); else n_pass++;
    n_checks++;
    if (bank_v_o !== 2'b00) $display("FAIL reset_bank_v got=%b exp=00", bank_v_o); else n_pass++;
    step();
    n_checks++;
    if (v_o !== 3'b000) $display("FAIL reset_v_o got=%b exp=000", v_o); else n_pass++;
    idle();
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    idle();
    v_i[0] = 1'b1; addr_i[0] = 11'h5;
    #1;
    n_checks++;
    if (yumi_o !== 3'b001) $display("FAIL single_yumi got=%b exp=001", yumi_o); else n_pass++;
    n_checks++;
    if (bank_v_o !== 2'b10 || bank_w_o !== 2'b00)
      $display("FAIL single_bank_vw got=%b/%b exp=10/00", bank_v_o, bank_w_o); else n_pass++;
    n_checks++;
    if (bank_addr_o[1] !== 10'h2) $display("FAIL single_addr got=%h exp=002", bank_addr_o[1]); else n_pass++;
    step();
    idle();
    #1;
    n_checks++;
    if (v_o !== 3'b001) $display("FAIL single_v_o got=%b exp=001", v_o); else n_pass++;
    n_checks++;
    if (data_o[0] !== B1_DATA) $display("FAIL single_data got=%h exp=%h", data_o[0], B1_DATA); else n_pass++;
    step();
    n_checks++;
    if (v_o !== 3'b000) $display("FAIL single_v_o_clear got=%b exp=000", v_o); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [NP-1:0] exp_y [8];
    exp_y = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100};
    idle();
    v_i = 3'b111;
    addr_i[0] = 11'h0; addr_i[1] = 11'h2; addr_i[2] = 11'h4;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (yumi_o !== exp_y[k]) $display("FAIL conflict_yumi cyc=%0d got=%b exp=%b", k, yumi_o, exp_y[k]); else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (v_o !== exp_y[k-1]) $display("FAIL conflict_v_o cyc=%0d got=%b exp=%b", k, v_o, exp_y[k-1]); else n_pass++;
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_parallel_write();
    idle();
    v_i = 3'b110; w_i = 3'b110;
    addr_i[2] = 11'h6; data_i[2] = 32'h1111_2222; mask_i[2] = 4'b1111;
    addr_i[1] = 11'h9; data_i[1] = 32'h3333_4444; mask_i[1] = 4'b0011;
    #1;
    n_checks++;
    if (yumi_o !== 3'b110) $display("FAIL par_yumi got=%b exp=110", yumi_o); else n_pass++;
    n_checks++;
    if (bank_v_o !== 2'b11 || bank_w_o !== 2'b11)
      $display("FAIL par_bank_vw got=%b/%b exp=11/11", bank_v_o, bank_w_o); else n_pass++;
    n_checks++;
    if (bank_addr_o[0] !== 10'h3 || bank_addr_o[1] !== 10'h4)
      $display("FAIL par_addr got=%h/%h exp=003/004", bank_addr_o[0], bank_addr_o[1]); else n_pass++;
    n_checks++;
    if (bank_data_o[0] !== 32'h1111_2222 || bank_data_o[1] !== 32'h3333_4444)
      $display("FAIL par_data got=%h/%h exp=11112222/33334444", bank_data_o[0], bank_data_o[1]); else n_pass++;
    step();
    idle();
    #1;
    n_checks++;
    if (v_o !== 3'b000) $display("FAIL par_no_v_o got=%b exp=000", v_o); else n_pass++;
    step();
  endtask

  task automatic test_write_mask();
    idle();
    v_i[1] = 1'b1; w_i[1] = 1'b1; addr_i[1] = 11'h3;
    data_i[1] = 32'hDEAD_BEEF; mask_i[1] = 4'b0101;
    #1;
    n_checks++;
    if (bank_v_o !== 2'b10 || bank_w_o !== 2'b10)
      $display("FAIL mask_bank_vw got=%b/%b exp=10/10", bank_v_o, bank_w_o); else n_pass++;
    n_checks++;
    if (bank_data_o[1] !== 32'hDEAD_BEEF || bank_mask_o[1] !== 4'b0101 || bank_addr_o[1] !== 10'h1)
      $display("FAIL mask_pass got=%h/%b/%h exp=deadbeef/0101/001", bank_data_o[1], bank_mask_o[1], bank_addr_o[1]); else n_pass++;
    n_checks++;
    if (bank_data_o[0] !== '0 || bank_mask_o[0] !== '0)
      $display("FAIL mask_idle_bank got=%h/%b exp=0/0", bank_data_o[0], bank_mask_o[0]); else n_pass++;
    step();
    idle();
    step();
  endtask

  task automatic test_no_reassign();
    idle();
    v_i = 3'b110; addr_i[1] = 11'h1; addr_i[2] = 11'h3;
    #1;
    n_checks++;
    if (yumi_o !== 3'b100 || bank_v_o !== 2'b10)
      $display("FAIL noreassign got=%b/%b exp=100/10", yumi_o, bank_v_o); else n_pass++;
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    v_i[0] = 1'b1; addr_i[0] = 11'h0;
    step();
    addr_i[0] = 11'h1;
    #1;
    n_checks++;
    if (v_o !== 3'b001 || data_o[0] !== B0_DATA)
      $display("FAIL b2b_first got=%b/%h exp=001/%h", v_o, data_o[0], B0_DATA); else n_pass++;
    step();
    idle();
    #1;
    n_checks++;
    if (v_o !== 3'b001 || data_o[0] !== B1_DATA)
      $display("FAIL b2b_second got=%b/%h exp=001/%h", v_o, data_o[0], B1_DATA); else n_pass++;
    step();
  endtask

  task automatic test_drop_clears();
    logic [NP-1:0] exp_y [9];
    exp_y = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    idle();
    addr_i[0] = 11'h0; addr_i[2] = 11'h2;
    for (int k = 0; k < 9; k++) begin
      v_i = (k == 3) ? 3'b100 : 3'b101;
      #1;
      n_checks++;
      if (yumi_o !== exp_y[k]) $display("FAIL drop_yumi cyc=%0d got=%b exp=%b", k, yumi_o, exp_y[k]); else n_pass++;
      step();
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_read();
    logic [NP-1:0] exp_y [5];
    exp_y = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
    idle();
    v_i = 3'b110; addr_i[1] = 11'h0; addr_i[2] = 11'h2;
    step(); step(); step();
    v_i[0] = 1'b1; addr_i[0] = 11'h5;
    #1;
    n_checks++;
    if (yumi_o !== 3'b101) $display("FAIL rst_pre_yumi got=%b exp=101", yumi_o); else n_pass++;
    @(negedge clk);
    reset_n_i = 1'b0;
    #1;
    n_checks++;
    if (v_o !== 3'b000 || yumi_o !== 3'b000 || bank_v_o !== 2'b00)
      $display("FAIL rst_async got=%b/%b/%b exp=000/000/00", v_o, yumi_o, bank_v_o); else n_pass++;
    step();
    n_checks++;
    if (v_o !== 3'b000) $display("FAIL rst_hold_v_o got=%b exp=000", v_o); else n_pass++;
    v_i = 3'b110;
    reset_n_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (yumi_o !== exp_y[k]) $display("FAIL rst_after_yumi cyc=%0d got=%b exp=%b", k, yumi_o, exp_y[k]); else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (v_o !== 3'b000) $display("FAIL rst_dropped_read got=%b exp=000", v_o); else n_pass++;
      end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_pass = 0;
    bank_data_i[0] = B0_DATA;
    bank_data_i[1] = B1_DATA;
    test_reset();
    test_single_read();
    test_conflict();
    test_parallel_write();
    test_write_mask();
    test_no_reassign();
    test_back_to_back();
    test_drop_clears();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_bank_arbiter.md
# bsg_manycore_bank_arbiter

Per-tile arbiter and sequencer for the banked local data/instruction memory. It takes N requester ports (instruction fetch, incoming network remote stores, core data port), steers each request to its bank, and grants one port per bank per cycle. Grants use fixed priority plus starvation aging, so remote stores cannot be locked out by the local core. Read data returns one cycle after grant and is steered back to the originating port. It sits between the tile's request sources and `num_banks_p` single-port 1RW SRAMs.

## Interface
- `num_ports_p`, 3: requester count; port `num_ports_p-1` has the highest static priority.
- `num_banks_p`, 2: bank count; power of two, ≥1.
- `bank_size_p`, "inv": words per bank.
- `data_width_p`, 32: word width.
- `starve_limit_p`, 4: consecutive denied cycles before a port becomes urgent; ≥1.
- `lg_banks_lp` = max(1, clog2(`num_banks_p`)); `bank_addr_width_lp` = clog2(`bank_size_p`); `addr_width_lp` = `bank_addr_width_lp` + clog2(`num_banks_p`).

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `v_i`  in  `num_ports_p`  request valid.
- `w_i`  in  `num_ports_p`  1 = write.
- `addr_i`  in  `num_ports_p`×`addr_width_lp`  word address (already swizzled).
- `data_i`  in  `num_ports_p`×`data_width_p`  write data.
- `mask_i`  in  `num_ports_p`×(`data_width_p`/8)  byte-enable mask.
- `yumi_o`  out  `num_ports_p`  request accepted this cycle.
- `v_o`  out  `num_ports_p`  read data valid.
- `data_o`  out  `num_ports_p`×`data_width_p`  read data.
- `bank_v_o`  out  `num_banks_p`  bank enable.
- `bank_w_o`  out  `num_banks_p`  bank write enable.
- `bank_addr_o`  out  `num_banks_p`×`bank_addr_width_lp`  bank-local address.
- `bank_data_o`  out  `num_banks_p`×`data_width_p`  bank write data.
- `bank_mask_o`  out  `num_banks_p`×(`data_width_p`/8)  bank byte mask.
- `bank_data_i`  in  `num_banks_p`×`data_width_p`  bank read data, valid the cycle after `bank_v_o` & ~`bank_w_o`.

## Operation
- Bank select = `addr_i[p][0+:clog2(num_banks_p)]`. Bank-local address = remaining upper bits. With `num_banks_p`=1, all requests go to bank 0 and the full address is used.
- Per bank, candidates are the ports with `v_i` whose bank select matches.
- Each port has a wait counter `wait_r[p]` (width clog2(`starve_limit_p`+1)):
  - increments when `v_i` & ~`yumi_o`;
  - saturates at `starve_limit_p`;
  - clears when `yumi_o` or ~`v_i`.
- A port is urgent when `wait_r` == `starve_limit_p`.
- Winner per bank:
  - highest-index urgent candidate if any urgent candidate exists;
  - otherwise the highest-index candidate.
- `yumi_o[p]` is combinational and asserts iff p wins its bank. At most one winner per bank; distinct banks grant in parallel.
- Winner's `w_i`/address/data/mask are driven onto that bank's `bank_*_o`, with `bank_v_o`=1.
- Idle bank: `bank_v_o`=0, `bank_w_o`=0; address/data/mask are don't-care, and the implementation drives 0.
- Read return:
  - On a granted read, register `rd_v_r[p]`=1 and `rd_bank_r[p]`=bank.
  - Next cycle `v_o[p]`=`rd_v_r[p]` and `data_o[p]`=`bank_data_i[rd_bank_r[p]]`.
  - Granted writes never raise `v_o`.
  - `data_o` is don't-care when `v_o`=0.
- Back-to-back reads from one port return on consecutive cycles. There is no output backpressure; consumers must sink `v_o`.

## Timing
- Grant: 0-cycle (`v_i`→`yumi_o` combinational). Read latency: 1 cycle from grant to `v_o`.
- Request may change freely when `yumi_o`=0. A requester must not depend on `yumi_o` to form `v_i`.
- Reset (asynchronous, `reset_n_i`=0):
  - `wait_r`, `rd_v_r`, `rd_bank_r` clear to 0 immediately;
  - `yumi_o`, `bank_v_o`, `bank_w_o`, `v_o` are forced to 0 while reset is asserted.
- Reset mid-operation: a read granted the cycle before reset asserts is dropped; `v_o` stays 0.
- First cycle after deassertion: normal arbitration with all counters at 0.
- Simultaneous urgent ports on one bank: highest index wins. The loser stays saturated and wins on a later cycle unless a higher-index urgent port persists.
- A port losing a bank conflict while another bank is idle is still denied; there is no bank reassignment.

## Structure
- Shared package `bsg_manycore_bank_arb_pkg` holds the width helpers (`lg_banks_lp`, mask-width calculation).
- Sub-module `bsg_manycore_bank_arb_pick` is instantiated once per bank. It takes the candidate vector and urgent vector and outputs a one-hot grant (combinational priority encode). The top module holds the counters, the return pipeline and the steering muxes.

## Test plan
- Single read: port 0 reads address 0x5 (bank 1, local 0x2) with 2 banks → `yumi_o`=001, `bank_v_o`=10, `bank_addr_o[1]`=0x2. Next cycle `v_o`=001 and `data_o[0]`=`bank_data_i[1]`.
- Conflict: ports 0, 1, 2 continuously read bank 0 with `starve_limit_p`=4 → port 2 granted cycles 0-3. Port 1 reaches urgent and wins at cycle 4; port 0 wins at cycle 5 (its counter saturated at cycle 4), then port 2 resumes.
- Parallel banks: port 2 writes bank 0 and port 1 writes bank 1 in the same cycle → `yumi_o`=110, `bank_v_o`=11, `bank_w_o`=11, `v_o` stays 000 the next cycle.
- Write mask pass-through: port 1 writes data 0xDEADBEEF with mask 0101 → matching `bank_data_o`/`bank_mask_o` on the target bank.
- Reset mid-read: grant a read on port 0 at cycle N and assert `reset_n_i` low asynchronously mid-cycle N+0.5 → `v_o`=0 immediately and through reset; counters read 0 after release.
- Saturation hold: deny port 0 for 10 cycles → `wait_r[0]`=4 (no wrap). Drop `v_i[0]` for one cycle → counter returns to 0.
